// File: rtl/spi_slave_responder.sv
// SPI responder clocked by PCLK: synchronizes the SPI pins, shifts 8-bit frames, offers valid/ready byte streams.
// Build option: define SPI_SLAVE_LSB_FIRST_EN for LSB-first frames; MSB-first when undefined.
module spi_slave_responder #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       sclk,
   input  logic       ss,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       busy,
   output logic       rx_overrun,
   output logic       tx_underrun,
   input  logic       clr_flags
);

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t              state;
   logic [SYNC_STAGES-1:0] sclk_sync_p;
   logic [SYNC_STAGES-1:0] ss_sync_p;
   logic [SYNC_STAGES-1:0] mosi_sync_p;
   logic                sclk_q;
   logic                ss_q;
   logic                sclk_s;
   logic                ss_s;
   logic                mosi_s;
   logic                cpol_l;
   logic                cpha_l;
   logic [2:0]          bit_cnt;
   logic [DATA_W-1:0]   tx_buf;
   logic [DATA_W-1:0]   tx_shift;
   logic [DATA_W-1:0]   rx_shift;
   logic [DATA_W-1:0]   load_byte;
   logic                sclk_edge;
   logic                lead_edge;
   logic                trail_edge;
   logic                sample_edge;
   logic                shift_edge;
   logic                ss_fall;
   logic                ss_rise;
   logic                tx_accept;
   logic                load_go;
   logic                sample_go;
   logic                shift_go;

   function automatic logic [DATA_W-1:0] rx_next(input logic [DATA_W-1:0] cur, input logic bit_in);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return {bit_in, cur[DATA_W-1:1]};
`else
      return {cur[DATA_W-2:0], bit_in};
`endif
   endfunction

   function automatic logic tx_bit(input logic [DATA_W-1:0] v);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return v[0];
`else
      return v[DATA_W-1];
`endif
   endfunction

   function automatic logic [DATA_W-1:0] tx_adv(input logic [DATA_W-1:0] v);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return {1'b0, v[DATA_W-1:1]};
`else
      return {v[DATA_W-2:0], 1'b0};
`endif
   endfunction

   // Synchronizer stages and registered copies for edge detection
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         sclk_sync_p <= '0;
         ss_sync_p   <= '1;
         sclk_q      <= 1'b0;
         ss_q        <= 1'b1;
      end else begin
         sclk_sync_p <= {sclk_sync_p[SYNC_STAGES-2:0], sclk};
         ss_sync_p   <= {ss_sync_p[SYNC_STAGES-2:0], ss};
         sclk_q      <= sclk_s;
         ss_q        <= ss_s;
      end
   end

   always_ff @(posedge PCLK) begin
      mosi_sync_p <= {mosi_sync_p[SYNC_STAGES-2:0], mosi};
   end

   assign sclk_s = sclk_sync_p[SYNC_STAGES-1];
   assign ss_s   = ss_sync_p[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_p[SYNC_STAGES-1];

   assign sclk_edge   = sclk_s ^ sclk_q;
   assign lead_edge   = sclk_edge & (sclk_s ^ cpol_l);
   assign trail_edge  = sclk_edge & ~(sclk_s ^ cpol_l);
   assign sample_edge = cpha_l ? trail_edge : lead_edge;
   assign shift_edge  = cpha_l ? lead_edge : trail_edge;
   assign ss_fall     = ss_q & ~ss_s;
   assign ss_rise     = ~ss_q & ss_s;
   assign tx_accept   = tx_valid & tx_ready;
   assign load_byte   = tx_ready ? IDLE_BYTE : tx_buf;

   // With cpha=0 the shift edge trailing the last sample belongs to the finished frame, so it is ignored at bit_cnt 0.
   assign load_go   = (state == S_LOAD) && !ss_rise;
   assign sample_go = (state == S_SHIFT) && !ss_rise && sample_edge;
   assign shift_go  = (state == S_SHIFT) && !ss_rise && shift_edge && (cpha_l || (bit_cnt != 3'd0));

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state       <= S_IDLE;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         tx_ready    <= 1'b1;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         busy        <= 1'b0;
         rx_overrun  <= 1'b0;
         tx_underrun <= 1'b0;
         bit_cnt     <= 3'd0;
         cpol_l      <= 1'b0;
         cpha_l      <= 1'b0;
      end else begin
         if (clr_flags) begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
         end
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
         if (load_go && !tx_ready)
            tx_ready <= 1'b1;
         else if (tx_accept)
            tx_ready <= 1'b0;

         case (state)
            S_IDLE: begin
               miso_oe <= 1'b0;
               busy    <= 1'b0;
               if (ss_fall) begin
                  cpol_l <= cpol;
                  cpha_l <= cpha;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (ss_rise) begin
                  state   <= S_IDLE;
                  miso_oe <= 1'b0;
                  busy    <= 1'b0;
                  bit_cnt <= 3'd0;
               end else begin
                  if (tx_ready)
                     tx_underrun <= 1'b1;
                  bit_cnt <= 3'd0;
                  miso_oe <= 1'b1;
                  busy    <= 1'b1;
                  state   <= S_SHIFT;
                  // A cpha=1 leading edge landing in this cycle still has to present the first bit.
                  if (!cpha_l || shift_edge)
                     miso <= tx_bit(load_byte);
               end
            end
            S_SHIFT: begin
               if (ss_rise) begin
                  state   <= S_IDLE;
                  miso_oe <= 1'b0;
                  busy    <= 1'b0;
                  bit_cnt <= 3'd0;
               end else if (sample_edge) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     state <= S_DONE;
               end else if (shift_go) begin
                  miso <= tx_bit(tx_shift);
               end
            end
            S_DONE: begin
               if (!rx_valid || rx_ready) begin
                  rx_data  <= rx_shift;
                  rx_valid <= 1'b1;
               end else begin
                  rx_overrun <= 1'b1;
               end
               if (ss_s) begin
                  state   <= S_IDLE;
                  miso_oe <= 1'b0;
                  busy    <= 1'b0;
               end else begin
                  state <= S_LOAD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Shift registers and TX holding buffer carry no reset; tx_ready marks buffer ownership.
   always_ff @(posedge PCLK) begin
      if (tx_accept)
         tx_buf <= tx_data;
      if (load_go)
         tx_shift <= (!cpha_l || shift_edge) ? tx_adv(load_byte) : load_byte;
      else if (shift_go)
         tx_shift <= tx_adv(tx_shift);
      if (sample_go)
         rx_shift <= rx_next(rx_shift, mosi_s);
   end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed plus randomized bench for spi_slave_responder, driving the SPI pins as a bit-banged master.
`timescale 1ns/1ps
module tb_spi_slave_responder;

   localparam int         H      = 10;
   localparam logic [7:0] IDLE_B = 8'hFF;

   logic       PCLK = 1'b0;
   logic       PRESET = 1'b1;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic       sclk = 1'b0;
   logic       ss = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic       miso_oe;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       busy;
   logic       rx_overrun;
   logic       tx_underrun;
   logic       clr_flags = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 PCLK = ~PCLK;

   spi_slave_responder #(.SYNC_STAGES(2), .IDLE_BYTE(IDLE_B)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss(ss),
      .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .clr_flags(clr_flags)
   );

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   // Byte as seen by an MSB-first master given the slave's bit order.
   function automatic logic [7:0] on_wire(input logic [7:0] b);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      return rev8(b);
`else
      return b;
`endif
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %02h, expected %02h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic set_mode(input logic pol, input logic pha);
      @(negedge PCLK);
      cpol = pol;
      cpha = pha;
      sclk = pol;
      wait_cyc(8);
   endtask

   task automatic push_tx(input logic [7:0] b);
      @(negedge PCLK);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge PCLK);
      tx_valid = 1'b0;
      chk("tx_ready_after_write", {7'd0, tx_ready}, 8'd0);
   endtask

   task automatic pop_rx();
      @(negedge PCLK);
      rx_ready = 1'b1;
      @(negedge PCLK);
      rx_ready = 1'b0;
      chk("rx_valid_after_accept", {7'd0, rx_valid}, 8'd0);
   endtask

   task automatic clear_flags();
      @(negedge PCLK);
      clr_flags = 1'b1;
      @(negedge PCLK);
      clr_flags = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_miso"}, {7'd0, miso}, 8'd0);
      chk({tag, "_miso_oe"}, {7'd0, miso_oe}, 8'd0);
      chk({tag, "_tx_ready"}, {7'd0, tx_ready}, 8'd1);
      chk({tag, "_rx_data"}, rx_data, 8'h00);
      chk({tag, "_rx_valid"}, {7'd0, rx_valid}, 8'd0);
      chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
      chk({tag, "_rx_overrun"}, {7'd0, rx_overrun}, 8'd0);
      chk({tag, "_tx_underrun"}, {7'd0, tx_underrun}, 8'd0);
   endtask

   // MSB-first master; when ending the frame, ss rises one PCLK after the final sample edge.
   task automatic spi_frame(input logic [7:0] out_b, input int nbits, input bit start_ss,
                            input bit end_ss, output logic [7:0] in_b);
      in_b = 8'h00;
      if (start_ss) ss = 1'b0;
      if (!cpha) mosi = out_b[7];
      wait_cyc(H);
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            sclk = ~sclk;
            in_b = {in_b[6:0], miso};
            if (i == 7 && end_ss) begin
               wait_cyc(1);
               ss = 1'b1;
               wait_cyc(H - 1);
            end else begin
               wait_cyc(H);
            end
            sclk = ~sclk;
            if (i < 7) mosi = out_b[6-i];
            wait_cyc(H);
         end else begin
            sclk = ~sclk;
            mosi = out_b[7-i];
            wait_cyc(H);
            sclk = ~sclk;
            in_b = {in_b[6:0], miso};
            if (i == 7 && end_ss) begin
               wait_cyc(1);
               ss = 1'b1;
            end
            wait_cyc(H);
         end
      end
      if (end_ss) wait_cyc(2 * H);
   endtask

   initial begin
      logic [7:0] got;
      logic [7:0] got2;
      logic [7:0] tb_b;
      logic [7:0] mb;
      logic       have;
      logic       pol;
      logic       pha;

      wait_cyc(4);
      PRESET = 1'b0;
      wait_cyc(2);
      check_reset_values("reset");

      // Mode 0 with a preloaded byte
      set_mode(1'b0, 1'b0);
      push_tx(8'hA5);
      spi_frame(8'h3C, 8, 1'b1, 1'b1, got);
      chk("m0_rx_valid", {7'd0, rx_valid}, 8'd1);
      chk("m0_rx_data", rx_data, on_wire(8'h3C));
      chk("m0_master_rx", got, on_wire(8'hA5));
      chk("m0_underrun", {7'd0, tx_underrun}, 8'd0);
      chk("m0_tx_ready", {7'd0, tx_ready}, 8'd1);
      chk("m0_miso_oe_idle", {7'd0, miso_oe}, 8'd0);
      pop_rx();

      // Mode 3
      set_mode(1'b1, 1'b1);
      push_tx(8'h5A);
      spi_frame(8'hC3, 8, 1'b1, 1'b1, got);
      chk("m3_rx_valid", {7'd0, rx_valid}, 8'd1);
      chk("m3_rx_data", rx_data, on_wire(8'hC3));
      chk("m3_master_rx", got, on_wire(8'h5A));
      pop_rx();

      // Underrun: nothing buffered
      set_mode(1'b0, 1'b0);
      spi_frame(8'h01, 8, 1'b1, 1'b1, got);
      chk("ur_master_rx", got, on_wire(IDLE_B));
      chk("ur_rx_data", rx_data, on_wire(8'h01));
      chk("ur_flag_set", {7'd0, tx_underrun}, 8'd1);
      clear_flags();
      chk("ur_flag_clr", {7'd0, tx_underrun}, 8'd0);
      pop_rx();

      // Back-to-back frames with consumer stalled
      spi_frame(8'h11, 8, 1'b1, 1'b0, got);
      spi_frame(8'h22, 8, 1'b0, 1'b1, got2);
      chk("b2b_rx_data", rx_data, on_wire(8'h11));
      chk("b2b_rx_valid", {7'd0, rx_valid}, 8'd1);
      chk("b2b_overrun", {7'd0, rx_overrun}, 8'd1);
      chk("b2b_master_rx2", got2, on_wire(IDLE_B));
      pop_rx();
      clear_flags();
      chk("b2b_overrun_clr", {7'd0, rx_overrun}, 8'd0);

      // Abort after 3 bits, then a full frame
      spi_frame(8'hFF, 3, 1'b1, 1'b0, got);
      chk("ab_busy_mid", {7'd0, busy}, 8'd1);
      chk("ab_oe_mid", {7'd0, miso_oe}, 8'd1);
      ss = 1'b1;
      wait_cyc(2 * H);
      chk("ab_oe_after", {7'd0, miso_oe}, 8'd0);
      chk("ab_busy_after", {7'd0, busy}, 8'd0);
      chk("ab_no_rx_valid", {7'd0, rx_valid}, 8'd0);
      spi_frame(8'h81, 8, 1'b1, 1'b1, got);
      chk("ab_full_rx_valid", {7'd0, rx_valid}, 8'd1);
      chk("ab_full_rx_data", rx_data, on_wire(8'h81));
      pop_rx();
      clear_flags();

      // Randomized frames against the reference model
      for (int k = 0; k < 10; k++) begin
         pol  = 1'($urandom_range(0, 1));
         pha  = 1'($urandom_range(0, 1));
         have = 1'($urandom_range(0, 1));
         tb_b = 8'($urandom);
         mb   = 8'($urandom);
         set_mode(pol, pha);
         if (have) push_tx(tb_b);
         spi_frame(mb, 8, 1'b1, 1'b1, got);
         chk("rnd_master_rx", got, on_wire(have ? tb_b : IDLE_B));
         chk("rnd_rx_data", rx_data, on_wire(mb));
         chk("rnd_underrun", {7'd0, tx_underrun}, {7'd0, ~have});
         pop_rx();
         clear_flags();
      end

      // PRESET in the middle of a frame with every flag and buffer busy
      set_mode(1'b0, 1'b0);
      spi_frame(8'h5A, 8, 1'b1, 1'b1, got);
      push_tx(8'hC3);
      spi_frame(8'h3C, 4, 1'b1, 1'b0, got);
      push_tx(8'h99);
      @(negedge PCLK);
      PRESET = 1'b1;
      @(negedge PCLK);
      check_reset_values("preset_mid");
      ss = 1'b1;
      sclk = 1'b0;
      wait_cyc(8);
      PRESET = 1'b0;
      wait_cyc(4);
      chk("post_reset_busy", {7'd0, busy}, 8'd0);

      // Normal operation after the mid-frame reset
      set_mode(1'b0, 1'b1);
      push_tx(8'h0F);
      spi_frame(8'hF0, 8, 1'b1, 1'b1, got);
      chk("post_reset_rx_data", rx_data, on_wire(8'hF0));
      chk("post_reset_master_rx", got, on_wire(8'h0F));
      chk("post_reset_underrun", {7'd0, tx_underrun}, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI slave (responder) that sits opposite the APB-programmed SPI master (`top`) on the sclk/ss/mosi/miso bus.
- Runs entirely on PCLK: oversamples the asynchronous SPI pins, detects sclk edges, and shifts 8-bit frames in and out.
- Exposes valid/ready byte streams to local logic. Used as the on-chip loopback responder and as the synthesizable bus-functional model for master regression.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sclk/ss/mosi (min 2).
- IDLE_BYTE, 8'hFF, byte shifted out on miso when no TX byte is buffered.

Ports:
- PCLK  input  1  system clock; must be ≥ 4x sclk frequency.
- PRESET  input  1  reset, synchronous, active-high.
- cpol  input  1  clock polarity; captured when ss falls.
- cpha  input  1  clock phase; captured when ss falls.
- sclk  input  1  SPI clock from master (async).
- ss  input  1  slave select, active-low (async).
- mosi  input  1  master-out data (async).
- miso  output  1  slave-out data.
- miso_oe  output  1  miso output enable (pad tri-state control).
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  TX holding buffer empty.
- rx_data  output  8  received byte.
- rx_valid  output  1  rx_data valid; held until accepted.
- rx_ready  input  1  consumer accepts rx_data.
- busy  output  1  frame in progress (ss asserted).
- rx_overrun  output  1  sticky flag.
- tx_underrun  output  1  sticky flag.
- clr_flags  input  1  clears both sticky flags.

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, rx_overrun=0, tx_underrun=0, FSM=IDLE. PRESET overrides everything, including a transfer in progress.
- Synchronization and edge detect:
  - sclk/ss/mosi pass through SYNC_STAGES flops.
  - An edge is detected when the synced value differs from its registered copy.
- Edge roles:
  - Leading edge = rising if cpol=0, falling if cpol=1.
  - Sample edge = leading if cpha=0, else trailing. Shift edge = the other edge.
- FSM IDLE:
  - miso_oe=0, busy=0.
  - On synced ss falling edge: latch cpol/cpha, go to LOAD.
- FSM LOAD (1 cycle):
  - Load tx_shift from the holding buffer and mark the buffer empty (tx_ready=1).
  - If the buffer is empty, load IDLE_BYTE and set tx_underrun.
  - bit_cnt=0, miso_oe=1, busy=1, go to SHIFT.
  - cpha=0: miso = tx_shift MSB immediately.
- FSM SHIFT:
  - Sample edge: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++.
  - Shift edge: miso = next TX bit.
  - cpha=1: the first shift edge drives the MSB, so no bit is consumed before it.
  - After the 8th sample: go to DONE.
- FSM DONE (1 cycle):
  - rx_valid=0 or rx_ready=1: rx_data <= rx_shift, rx_valid=1.
  - Else: the new byte is dropped, rx_data is unchanged, rx_overrun=1.
  - If ss is still low: go to LOAD (back-to-back frame). Else go to IDLE.
- Latency: rx_valid rises exactly 2 PCLK cycles after the cycle in which the 8th sample edge is detected.
- RX handshake: rx_valid && rx_ready in the same cycle transfers the byte; rx_valid drops next cycle unless DONE refills it that cycle, in which case rx_valid stays 1.
- TX handshake:
  - Write accepted when tx_valid && tx_ready; tx_ready=0 the next cycle.
  - Simultaneous accept and LOAD: LOAD takes the old buffer state. If the buffer was empty, send IDLE_BYTE, and the new byte waits for the next frame.
- ss deassert (synced rising) in any non-IDLE state:
  - Abort: discard the partial rx_shift, no rx_valid, bit_cnt=0.
  - miso_oe=0 the next cycle, return to IDLE.
  - A TX byte already loaded is lost; the holding buffer is untouched.
- Flags:
  - clr_flags clears both flags.
  - If clr_flags coincides with a set event, the set wins.
- cpol/cpha changes while busy are ignored.

Optional Feature:
- Macro SPI_SLAVE_LSB_FIRST_EN, with the rules below.
- Defined: frames are LSB-first.
  - rx_shift shifts right, taking mosi into bit 7.
  - miso drives tx_shift[0] and shifts right.
- Undefined: MSB-first, as above.
- Handshakes, timing and flags are identical in both builds.

Test Plan:
1. Mode 0, tx_data=8'hA5 preloaded; master sends 8'h3C → rx_data=8'h3C with rx_valid=1; master reads 8'hA5; tx_underrun=0.
2. Mode 3 (cpol=1, cpha=1), tx=8'h5A; master sends 8'hC3 → rx_data=8'hC3; master receives 8'h5A.
3. No TX preloaded, master sends 8'h01 → master receives 8'hFF; tx_underrun=1; clr_flags pulse → 0.
4. Two back-to-back frames 8'h11, 8'h22 with rx_ready=0 → rx_data=8'h11, rx_overrun=1. Then rx_ready=1 → rx_valid drops next cycle.
5. ss raised after 3 bits of 8'hFF, then a full frame 8'h81 → a single rx_valid, rx_data=8'h81; miso_oe=0 between frames.
6. PRESET asserted mid-frame (bit 4) → all outputs at reset values next cycle. With SPI_SLAVE_LSB_FIRST_EN, master sending 8'h3C MSB-first → rx_data=8'h3C bit-reversed, i.e. 8'h3C.
